card_match_judge: RTL and testbench

Parametrised match judge for the memory card game. It collects GROUP card selections from the board cursor and fetches each card's value from the synchronous card memory. Once the group is complete it declares a match or a mismatch, tracks which cards are already matched, holds mismatched cards face-up for a fixed reveal time, and raises game-over when every group is found. It sits between the game-state controller and the card memory, and drives the VGA reveal and score logic.

---
 rtl/card_match_judge.sv | 235 +++++++++++++++++++++++
 tb/tb_card_match_judge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_match_judge.sv
// Memory-game match judge: gathers GROUP picks, reads each value from the synchronous card memory and
// judges match/mismatch. Optional build macro MATCH_MOVE_COUNT_EN keeps the completed-turn counter.
module card_match_judge #(
    parameter int ADDR_W      = 6,
    parameter int VAL_W       = 5,
    parameter int GROUP       = 2,
    parameter int NUM_GROUPS  = 18,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MOVES_W     = 10
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             new_game,
    input  logic                             select,
    input  logic [ADDR_W-1:0]                sel_addr,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [VAL_W-1:0]                 mem_data,
    output logic                             sel_reject,
    output logic                             busy,
    output logic [$clog2(GROUP+1)-1:0]       sel_count,
    output logic [GROUP*VAL_W-1:0]           card_val,
    output logic [GROUP*ADDR_W-1:0]          card_addr,
    output logic                             reveal,
    output logic                             match_pulse,
    output logic                             mismatch_pulse,
    output logic [2**ADDR_W-1:0]             matched_mask,
    output logic [$clog2(NUM_GROUPS+1)-1:0]  pairs_found,
    output logic [MOVES_W-1:0]               moves,
    output logic                             game_over
);
    localparam int SEL_W     = $clog2(GROUP + 1);
    localparam int PF_W      = $clog2(NUM_GROUPS + 1);
    localparam int NUM_CARDS = GROUP * NUM_GROUPS;
    localparam int TMR_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    generate
        if (GROUP < 2 || GROUP > 4 || NUM_CARDS > 2**ADDR_W) begin : g_param_check
            $error("card_match_judge: GROUP must be 2..4 and GROUP*NUM_GROUPS must fit the board");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPT, S_EVAL, S_SHOW, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    sel_reject_q, sel_reject_d;
    logic                    busy_q, busy_d;
    logic [SEL_W-1:0]        sel_count_q, sel_count_d;
    logic [GROUP*VAL_W-1:0]  card_val_q, card_val_d;
    logic [GROUP*ADDR_W-1:0] card_addr_q, card_addr_d;
    logic                    reveal_q, reveal_d;
    logic                    match_q, match_d;
    logic                    mismatch_q, mismatch_d;
    logic [2**ADDR_W-1:0]    matched_mask_q, matched_mask_d;
    logic [PF_W-1:0]         pairs_found_q, pairs_found_d;
    logic                    game_over_q, game_over_d;
    logic [TMR_W-1:0]        timer_q, timer_d;

    logic [VAL_W-1:0]  val_slot  [GROUP];
    logic [ADDR_W-1:0] addr_slot [GROUP];

    genvar gi;
    generate
        for (gi = 0; gi < GROUP; gi++) begin : g_slot
            assign val_slot[gi]  = card_val_q[gi*VAL_W +: VAL_W];
            assign addr_slot[gi] = card_addr_q[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    logic dup_hit, all_equal, accept;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < GROUP; i++)
            if (SEL_W'(i) < sel_count_q && addr_slot[i] == sel_addr) dup_hit = 1'b1;
        all_equal = 1'b1;
        for (int i = 1; i < GROUP; i++)
            if (val_slot[i] != val_slot[0]) all_equal = 1'b0;
        accept = (state_q == S_IDLE) && select && enable && (32'(sel_addr) < NUM_CARDS)
                 && !matched_mask_q[sel_addr] && !dup_hit;
    end

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        sel_reject_d   = 1'b0;
        sel_count_d    = sel_count_q;
        card_val_d     = card_val_q;
        card_addr_d    = card_addr_q;
        match_d        = 1'b0;
        mismatch_d     = 1'b0;
        matched_mask_d = matched_mask_q;
        pairs_found_d  = pairs_found_q;
        game_over_d    = game_over_q;
        timer_d        = timer_q;
        if (new_game) begin
            state_d        = S_IDLE;
            mem_addr_d     = '0;
            sel_count_d    = '0;
            card_val_d     = '0;
            card_addr_d    = '0;
            matched_mask_d = '0;
            pairs_found_d  = '0;
            game_over_d    = 1'b0;
            timer_d        = '0;
        end else begin
            sel_reject_d = select && !accept;
            // Leaving the play state abandons the turn but keeps the score.
            if (!enable && state_q != S_DONE) begin
                state_d     = S_IDLE;
                sel_count_d = '0;
                timer_d     = '0;
            end else begin
                case (state_q)
                    S_IDLE: if (accept) begin
                        mem_addr_d = sel_addr;
                        for (int i = 0; i < GROUP; i++)
                            if (sel_count_q == SEL_W'(i)) card_addr_d[i*ADDR_W +: ADDR_W] = sel_addr;
                        state_d = S_WAIT;
                    end
                    S_WAIT: state_d = S_CAPT;
                    S_CAPT: begin
                        for (int i = 0; i < GROUP; i++)
                            if (sel_count_q == SEL_W'(i)) card_val_d[i*VAL_W +: VAL_W] = mem_data;
                        sel_count_d = sel_count_q + 1'b1;
                        state_d = (sel_count_q == SEL_W'(GROUP - 1)) ? S_EVAL : S_IDLE;
                    end
                    S_EVAL: begin
                        if (all_equal) begin
                            match_d = 1'b1;
                            for (int i = 0; i < GROUP; i++) matched_mask_d[addr_slot[i]] = 1'b1;
                            pairs_found_d = pairs_found_q + 1'b1;
                            sel_count_d   = '0;
                            if (pairs_found_q == PF_W'(NUM_GROUPS - 1)) begin
                                game_over_d = 1'b1;
                                state_d     = S_DONE;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            if (HOLD_CYCLES == 0) begin
                                sel_count_d = '0;
                                state_d     = S_IDLE;
                            end else begin
                                timer_d = TMR_W'(HOLD_CYCLES);
                                state_d = S_SHOW;
                            end
                        end
                    end
                    S_SHOW: begin
                        if (timer_q <= TMR_W'(1)) begin
                            timer_d     = '0;
                            sel_count_d = '0;
                            state_d     = S_IDLE;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                    S_DONE: state_d = S_DONE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        reveal_d = (state_d == S_SHOW);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            mem_addr_q     <= '0;
            sel_reject_q   <= 1'b0;
            busy_q         <= 1'b0;
            sel_count_q    <= '0;
            card_val_q     <= '0;
            card_addr_q    <= '0;
            reveal_q       <= 1'b0;
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            matched_mask_q <= '0;
            pairs_found_q  <= '0;
            game_over_q    <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            sel_reject_q   <= sel_reject_d;
            busy_q         <= busy_d;
            sel_count_q    <= sel_count_d;
            card_val_q     <= card_val_d;
            card_addr_q    <= card_addr_d;
            reveal_q       <= reveal_d;
            match_q        <= match_d;
            mismatch_q     <= mismatch_d;
            matched_mask_q <= matched_mask_d;
            pairs_found_q  <= pairs_found_d;
            game_over_q    <= game_over_d;
            timer_q        <= timer_d;
        end
    end

`ifdef MATCH_MOVE_COUNT_EN
    logic [MOVES_W-1:0] moves_q, moves_d;

    always_comb begin
        moves_d = moves_q;
        if (new_game) moves_d = '0;
        else if (state_q == S_EVAL && enable && moves_q != '1) moves_d = moves_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) moves_q <= '0;
        else          moves_q <= moves_d;
    end

    assign moves = moves_q;
`else
    assign moves = '0;
`endif

    assign mem_addr       = mem_addr_q;
    assign sel_reject     = sel_reject_q;
    assign busy           = busy_q;
    assign sel_count      = sel_count_q;
    assign card_val       = card_val_q;
    assign card_addr      = card_addr_q;
    assign reveal         = reveal_q;
    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;
    assign matched_mask   = matched_mask_q;
    assign pairs_found    = pairs_found_q;
    assign game_over      = game_over_q;
endmodule

// File: tb/tb_card_match_judge.sv
// Directed bench for card_match_judge: a pair-game instance (HOLD_CYCLES=4) and a triple-game
// instance (HOLD_CYCLES=0), each fed by a synchronous memory model; result strobes go through a scoreboard.
module tb_card_match_judge;
    localparam int AW = 6;
    localparam int VW = 5;
`ifdef MATCH_MOVE_COUNT_EN
    localparam int MOVES_ON = 1;
`else
    localparam int MOVES_ON = 0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic en0 = 1'b1, ng0 = 1'b0, sel0 = 1'b0;
    logic [AW-1:0] sa0 = '0, ma0;
    logic [VW-1:0] md0;
    logic rej0, busy0, rev0, mp0, mmp0, go0;
    logic [1:0] sc0;
    logic [2*VW-1:0] cv0;
    logic [2*AW-1:0] ca0;
    logic [63:0] mask0;
    logic [4:0] pf0;
    logic [9:0] mv0;

    logic en1 = 1'b1, ng1 = 1'b0, sel1 = 1'b0;
    logic [AW-1:0] sa1 = '0, ma1;
    logic [VW-1:0] md1;
    logic rej1, busy1, rev1, mp1, mmp1, go1;
    logic [1:0] sc1;
    logic [3*VW-1:0] cv1;
    logic [3*AW-1:0] ca1;
    logic [63:0] mask1;
    logic [4:0] pf1;
    logic [9:0] mv1;

    logic [VW-1:0] mem0 [64];
    logic [VW-1:0] mem1 [64];
    always @(posedge clock) begin
        md0 <= mem0[ma0];
        md1 <= mem1[ma1];
    end

    card_match_judge #(.GROUP(2), .NUM_GROUPS(18), .HOLD_CYCLES(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .enable(en0), .new_game(ng0), .select(sel0),
        .sel_addr(sa0), .mem_addr(ma0), .mem_data(md0), .sel_reject(rej0), .busy(busy0),
        .sel_count(sc0), .card_val(cv0), .card_addr(ca0), .reveal(rev0), .match_pulse(mp0),
        .mismatch_pulse(mmp0), .matched_mask(mask0), .pairs_found(pf0), .moves(mv0), .game_over(go0));

    card_match_judge #(.GROUP(3), .NUM_GROUPS(18), .HOLD_CYCLES(0)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(en1), .new_game(ng1), .select(sel1),
        .sel_addr(sa1), .mem_addr(ma1), .mem_data(md1), .sel_reject(rej1), .busy(busy1),
        .sel_count(sc1), .card_val(cv1), .card_addr(ca1), .reveal(rev1), .match_pulse(mp1),
        .mismatch_pulse(mmp1), .matched_mask(mask1), .pairs_found(pf1), .moves(mv1), .game_over(go1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: 1 = match expected, 0 = mismatch expected.
    bit exp0_q[$];
    bit exp1_q[$];
    bit e0, e1;
    always @(negedge clock) begin
        if (mp0 || mmp0) begin
            if (exp0_q.size() == 0) chk("dut0 unexpected strobe", {mp0, mmp0}, 2'b00);
            else begin
                e0 = exp0_q.pop_front();
                chk("dut0 result", {mp0, mmp0}, e0 ? 2'b10 : 2'b01);
            end
        end
        if (mp1 || mmp1) begin
            if (exp1_q.size() == 0) chk("dut1 unexpected strobe", {mp1, mmp1}, 2'b00);
            else begin
                e1 = exp1_q.pop_front();
                chk("dut1 result", {mp1, mmp1}, e1 ? 2'b10 : 2'b01);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pick(input int which, input int addr, output logic rej);
        if (which == 0) begin sel0 = 1'b1; sa0 = AW'(addr); end
        else            begin sel1 = 1'b1; sa1 = AW'(addr); end
        @(negedge clock);
        sel0 = 1'b0;
        sel1 = 1'b0;
        rej = (which == 0) ? rej0 : rej1;
        $display("pick dut%0d addr %0d -> %s", which, addr, rej ? "rejected" : "accepted");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        int cnt;
        int np;
        for (int a = 0; a < 64; a++) begin
            mem0[a] = (a < 36) ? VW'((a >> 1) + 10) : '0;
            mem1[a] = VW'(a / 3 + 1);
        end
        mem0[0] = 5'd7; mem0[1] = 5'd7;
        mem0[2] = 5'd3; mem0[3] = 5'd3;
        mem0[4] = 5'd9; mem0[5] = 5'd9;

        step(2);
        chk("reset sel_count", sc0, 0);
        chk("reset mask", mask0, 0);
        chk("reset pairs", pf0, 0);
        chk("reset game_over", go0, 0);
        chk("reset busy/reveal/reject", {busy0, rev0, rej0, mp0, mmp0}, 0);
        chk("reset mem_addr/card", {ma0, cv0, ca0, mv0}, 0);
        reset_n = 1'b1;
        step(1);

        // Matching pair at slots 0 and 1, second pick 3 cycles after the first.
        pick(0, 0, r); chk("t1 accept first", r, 0); chk("t1 busy", busy0, 1);
        step(2);
        chk("t1 count after capture", sc0, 1);
        chk("t1 captured value", cv0[VW-1:0], 7);
        exp0_q.push_back(1'b1);
        pick(0, 1, r); chk("t1 accept second", r, 0);
        step(2); chk("t1 count full", sc0, 2);
        step(1);
        chk("t1 match strobe at E3", mp0, 1);
        chk("t1 mask", mask0[1:0], 2'b11);
        chk("t1 pairs", pf0, 1);
        chk("t1 moves", mv0, MOVES_ON);
        chk("t1 count cleared", sc0, 0);

        // Mismatch 3 vs 9 with a 4-cycle reveal; also an early select inside the 3-cycle spacing.
        pick(0, 2, r); chk("t2 accept 2", r, 0);
        pick(0, 3, r); chk("t2 early select rejected", r, 1);
        step(1); chk("t2 count", sc0, 1);
        exp0_q.push_back(1'b0);
        pick(0, 4, r); chk("t2 accept 4", r, 0);
        step(3);
        chk("t2 mismatch strobe", mmp0, 1);
        chk("t2 reveal on", rev0, 1);
        chk("t2 moves", mv0, 2 * MOVES_ON);
        cnt = 0;
        while (rev0 && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                pick(0, 6, r); chk("t2 select during reveal", r, 1);
            end else step(1);
        end
        chk("t2 reveal length", cnt, 4);
        chk("t2 count after reveal", sc0, 0);
        chk("t2 card_addr retained", ca0, {6'd4, 6'd2});
        chk("t2 pairs unchanged", pf0, 1);

        // Illegal selects: duplicate, already matched, out of range.
        pick(0, 6, r); chk("t3 accept 6", r, 0);
        step(2); chk("t3 count", sc0, 1);
        pick(0, 6, r);  chk("t3 duplicate rejected", r, 1);  chk("t3 count dup", sc0, 1);
        pick(0, 0, r);  chk("t3 matched rejected", r, 1);    chk("t3 count matched", sc0, 1);
        pick(0, 36, r); chk("t3 range rejected", r, 1);      chk("t3 count range", sc0, 1);
        exp0_q.push_back(1'b1);
        pick(0, 7, r); chk("t3 accept 7", r, 0);
        step(3);
        chk("t3 match", mp0, 1);
        chk("t3 pairs", pf0, 2);

        // Enable drop mid-turn.
        pick(0, 8, r); chk("t4 accept 8", r, 0);
        step(2); chk("t4 count", sc0, 1);
        en0 = 1'b0;
        step(1);
        chk("t4 aborted count", sc0, 0);
        chk("t4 idle", busy0, 0);
        chk("t4 pairs kept", pf0, 2);
        chk("t4 moves kept", mv0, 3 * MOVES_ON);
        chk("t4 mask kept", mask0, 64'hC3);
        en0 = 1'b1;

        // Play the rest of the board.
        np = 2;
        for (int k = 1; k < 18; k++) begin
            if (k != 3) begin
                pick(0, 2 * k, r);
                step(2);
                exp0_q.push_back(1'b1);
                pick(0, 2 * k + 1, r);
                step(3);
                np++;
                chk("t5 pairs progress", pf0, np);
            end
        end
        chk("t5 game_over", go0, 1);
        chk("t5 mask full", mask0, 64'h0000_000F_FFFF_FFFF);
        chk("t5 moves", mv0, 19 * MOVES_ON);
        chk("t5 not busy", busy0, 0);
        pick(0, 40, r); chk("t5 select after win", r, 1);
        step(2);
        chk("t5 game_over held", go0, 1);
        chk("t5 count", sc0, 0);

        ng0 = 1'b1;
        step(1);
        ng0 = 1'b0;
        chk("t6 new_game game_over", go0, 0);
        chk("t6 new_game pairs", pf0, 0);
        chk("t6 new_game mask", mask0, 0);
        chk("t6 new_game cards", {cv0, ca0, mv0, sc0}, 0);

        // Asynchronous reset while waiting on memory.
        pick(0, 10, r); chk("t7 accept 10", r, 0);
        chk("t7 mem_addr", ma0, 10);
        chk("t7 busy", busy0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t7 async reset busy", busy0, 0);
        chk("t7 async reset mem_addr", ma0, 0);
        chk("t7 async reset card_addr", ca0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1);

        // Triple game: no strobe until the third capture.
        pick(1, 0, r); chk("t8 accept 0", r, 0);
        step(2);
        pick(1, 1, r); chk("t8 accept 1", r, 0);
        step(2); chk("t8 count two", sc1, 2);
        step(1); chk("t8 no early strobe", {mp1, mmp1}, 0);
        exp1_q.push_back(1'b1);
        pick(1, 2, r); chk("t8 accept 2", r, 0);
        step(3);
        chk("t8 match", mp1, 1);
        chk("t8 pairs", pf1, 1);
        chk("t8 mask", mask1[2:0], 3'b111);

        // Zero hold time: mismatch goes straight back to IDLE.
        pick(1, 3, r); step(2);
        pick(1, 4, r); step(2);
        exp1_q.push_back(1'b0);
        pick(1, 6, r); chk("t9 accept 6", r, 0);
        step(3);
        chk("t9 mismatch", mmp1, 1);
        chk("t9 no reveal", rev1, 0);
        chk("t9 count cleared", sc1, 0);
        pick(1, 9, r); chk("t9 immediate select", r, 0);
        step(2); chk("t9 count", sc1, 1);

        step(2);
        chk("scoreboard dut0 drained", exp0_q.size(), 0);
        chk("scoreboard dut1 drained", exp1_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
